// File: rtl/lc_mem_pkg.sv
// Shared constants, FSM states and address helper for the logic-capture DDR readback path.
package lc_mem_pkg;

  localparam int SAMPLE_W         = 32;
  localparam int LINE_W           = 128;
  localparam int SAMPLES_PER_LINE = 4;
  localparam int LINE_ADX_STRIDE  = 8;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_DONE,
    ST_DRAIN
  } state_e;

  // Four samples share one 128-bit line, and lines sit 8 address units apart.
  function automatic logic [31:0] sample_to_line_adx(input logic [31:0] sample);
    return {sample[30:2], 3'b000};
  endfunction

endpackage

// File: rtl/dram_read_issuer.sv
// Issues 128-bit line reads for a transfer and bounds how many are in flight.
module dram_read_issuer
  import lc_mem_pkg::*;
#(
  parameter  int IDX_W           = 25,
  parameter  int ADX_W           = 27,
  parameter  int MAX_OUTSTANDING = 4,
  localparam int OUT_W           = $clog2(MAX_OUTSTANDING + 1)
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             load_i,
  input  logic [ADX_W-1:0] first_adx_i,
  input  logic [IDX_W:0]   lines_total_i,
  input  logic             enable_i,
  input  logic             read_allowed_i,
  input  logic             pop_i,
  output logic             read_req_o,
  output logic [ADX_W-1:0] rd_adx_o,
  output logic [OUT_W-1:0] outstanding_o
);

  localparam logic [OUT_W-1:0] MaxOut = OUT_W'(MAX_OUTSTANDING);

  logic [IDX_W:0]   issued_q, issued_d;
  logic [ADX_W-1:0] adx_q, adx_d;
  logic [OUT_W-1:0] out_q, out_d;

  always_comb begin
    read_req_o = enable_i && (issued_q < lines_total_i) && (out_q < MaxOut) && read_allowed_i;
    issued_d   = issued_q;
    adx_d      = adx_q;
    out_d      = out_q;
    if (load_i) begin
      issued_d = '0;
      adx_d    = first_adx_i;
    end else if (read_req_o) begin
      issued_d = issued_q + (IDX_W+1)'(1);
      adx_d    = adx_q + ADX_W'(LINE_ADX_STRIDE);
    end
    // A same-cycle issue and pop cancel out.
    if (read_req_o && !pop_i) begin
      out_d = out_q + OUT_W'(1);
    end else if (!read_req_o && pop_i && (out_q != '0)) begin
      out_d = out_q - OUT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      issued_q <= '0;
      adx_q    <= '0;
      out_q    <= '0;
    end else begin
      issued_q <= issued_d;
      adx_q    <= adx_d;
      out_q    <= out_d;
    end
  end

  assign rd_adx_o      = adx_q;
  assign outstanding_o = out_q;

endmodule

// File: rtl/dram_unpacker.sv
// Reads a sample range back from DDR as 128-bit lines and streams it out as 32-bit samples.
module dram_unpacker
  import lc_mem_pkg::*;
#(
  parameter int IDX_W           = 25,
  parameter int ADX_W           = 27,
  parameter int MAX_OUTSTANDING = 4
) (
  input  logic                clk,
  input  logic                resetn,
  input  logic                start,
  input  logic [IDX_W-1:0]    start_sample,
  input  logic [IDX_W-1:0]    sample_count,
  input  logic                abort,
  output logic                busy,
  output logic                done,
  output logic                adx_error,
  output logic                read_req,
  output logic [ADX_W-1:0]    rd_adx,
  input  logic                read_allowed,
  input  logic                has_return_data,
  output logic                get_return_data,
  input  logic [LINE_W-1:0]   return_data,
  input  logic [ADX_W-1:0]    return_adx,
  output logic [SAMPLE_W-1:0] sample_out,
  output logic                sample_valid,
  input  logic                sample_ready
);

  localparam int OUT_W = $clog2(MAX_OUTSTANDING + 1);

  state_e            state_q, state_d;
  logic [1:0]        lane0_q, lane0_d, lane_q, lane_d;
  logic [IDX_W-1:0]  count_q, count_d, sent_q, sent_d;
  logic [IDX_W:0]    lines_total_q, lines_total_d, span;
  logic [ADX_W-1:0]  fetch_adx_q, fetch_adx_d, first_adx;
  logic [LINE_W-1:0] hold_q, hold_d;
  logic              first_q, first_d, valid_q, valid_d, adx_err_q, adx_err_d, done_q;
  logic [OUT_W-1:0]  outstanding;
  logic              start_acc, run_abort, issue_en, fetch, handshake, last_lane;

  assign first_adx = ADX_W'(sample_to_line_adx(32'(start_sample)));
  assign span      = (IDX_W+1)'(start_sample[1:0]) + (IDX_W+1)'(sample_count) + (IDX_W+1)'(3);

  dram_read_issuer #(
    .IDX_W          (IDX_W),
    .ADX_W          (ADX_W),
    .MAX_OUTSTANDING(MAX_OUTSTANDING)
  ) u_issuer (
    .clk           (clk),
    .resetn        (resetn),
    .load_i        (start_acc),
    .first_adx_i   (first_adx),
    .lines_total_i (lines_total_q),
    .enable_i      (issue_en),
    .read_allowed_i(read_allowed),
    .pop_i         (get_return_data),
    .read_req_o    (read_req),
    .rd_adx_o      (rd_adx),
    .outstanding_o (outstanding)
  );

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) state_q <= ST_IDLE;
    else         state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (start_acc) state_d = (sample_count == '0) ? ST_DONE : ST_RUN;
      ST_RUN: begin
        if (abort) state_d = ST_DRAIN;
        else if ((sent_q == count_q) && (outstanding == '0)) state_d = ST_DONE;
      end
      ST_DONE:  state_d = ST_IDLE;
      ST_DRAIN: if (outstanding == '0) state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // Abort takes priority over both start and any fetch in the same cycle.
  always_comb begin
    start_acc       = (state_q == ST_IDLE) && start && !abort;
    run_abort       = (state_q == ST_RUN) && abort;
    issue_en        = (state_q == ST_RUN) && !abort;
    fetch           = issue_en && !valid_q && has_return_data;
    get_return_data = fetch || ((state_q == ST_DRAIN) && has_return_data && (outstanding != '0));
    handshake       = valid_q && sample_ready;
    busy            = (state_q != ST_IDLE);
  end

  always_comb begin
    lane0_d       = lane0_q;
    count_d       = count_q;
    lines_total_d = lines_total_q;
    sent_d        = sent_q;
    fetch_adx_d   = fetch_adx_q;
    first_d       = first_q;
    valid_d       = valid_q;
    adx_err_d     = adx_err_q;
    hold_d        = hold_q;
    lane_d        = lane_q;
    last_lane     = (lane_q == 2'(SAMPLES_PER_LINE - 1)) || ((sent_q + IDX_W'(1)) == count_q);
    if (start_acc) begin
      lane0_d       = start_sample[1:0];
      count_d       = sample_count;
      lines_total_d = span >> 2;
      sent_d        = '0;
      fetch_adx_d   = first_adx;
      first_d       = 1'b1;
      valid_d       = 1'b0;
      adx_err_d     = 1'b0;
    end else if (run_abort) begin
      valid_d = 1'b0;
    end else if (fetch) begin
      hold_d      = return_data;
      lane_d      = first_q ? lane0_q : 2'd0;
      first_d     = 1'b0;
      valid_d     = 1'b1;
      fetch_adx_d = fetch_adx_q + ADX_W'(LINE_ADX_STRIDE);
      if (return_adx != fetch_adx_q) adx_err_d = 1'b1;
    end else if (handshake) begin
      // Trailing lanes past the requested count are simply dropped.
      sent_d = sent_q + IDX_W'(1);
      if (last_lane) valid_d = 1'b0;
      else           lane_d  = lane_q + 2'd1;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      lane0_q       <= '0;
      count_q       <= '0;
      lines_total_q <= '0;
      sent_q        <= '0;
      fetch_adx_q   <= '0;
      first_q       <= 1'b0;
      valid_q       <= 1'b0;
      adx_err_q     <= 1'b0;
      hold_q        <= '0;
      lane_q        <= '0;
      done_q        <= 1'b0;
    end else begin
      lane0_q       <= lane0_d;
      count_q       <= count_d;
      lines_total_q <= lines_total_d;
      sent_q        <= sent_d;
      fetch_adx_q   <= fetch_adx_d;
      first_q       <= first_d;
      valid_q       <= valid_d;
      adx_err_q     <= adx_err_d;
      hold_q        <= hold_d;
      lane_q        <= lane_d;
      done_q        <= (state_q == ST_DONE);
    end
  end

  assign done         = done_q;
  assign adx_error    = adx_err_q;
  assign sample_valid = valid_q;
  assign sample_out   = hold_q[{lane_q, 5'd0} +: SAMPLE_W];

endmodule

// File: tb/tb_dram_unpacker.sv
// Directed bench for dram_unpacker: an in-order DDR return model plus a sample-stream scoreboard.
module tb_dram_unpacker;

  localparam int IDX_W = 25;
  localparam int ADX_W = 27;
  localparam int MAXO  = 4;

  logic              clk = 1'b0;
  logic              resetn = 1'b0;
  logic              start = 1'b0;
  logic [IDX_W-1:0]  start_sample = '0;
  logic [IDX_W-1:0]  sample_count = '0;
  logic              abort = 1'b0;
  logic              busy, done, adx_error, read_req, get_return_data, sample_valid;
  logic [ADX_W-1:0]  rd_adx;
  logic              read_allowed = 1'b1;
  logic              has_return_data = 1'b0;
  logic [127:0]      return_data = '0;
  logic [ADX_W-1:0]  return_adx = '0;
  logic [31:0]       sample_out;
  logic              sample_ready = 1'b1;

  always #5 clk = ~clk;

  dram_unpacker #(.IDX_W(IDX_W), .ADX_W(ADX_W), .MAX_OUTSTANDING(MAXO)) dut (
    .clk(clk), .resetn(resetn), .start(start), .start_sample(start_sample),
    .sample_count(sample_count), .abort(abort), .busy(busy), .done(done),
    .adx_error(adx_error), .read_req(read_req), .rd_adx(rd_adx),
    .read_allowed(read_allowed), .has_return_data(has_return_data),
    .get_return_data(get_return_data), .return_data(return_data),
    .return_adx(return_adx), .sample_out(sample_out), .sample_valid(sample_valid),
    .sample_ready(sample_ready)
  );

  typedef struct {
    logic [ADX_W-1:0] adx;
    int               rdy;
  } ret_t;

  ret_t             memQ[$];
  logic [ADX_W-1:0] expRd[$];
  logic [31:0]      expSmp[$];
  int               errors = 0, checks = 0, cyc = 0, retLat = 1;
  int               sentCnt = 0, doneCnt = 0, readCnt = 0, maxOut = 0;
  logic             corruptEn = 1'b0, expErr = 1'b0;
  logic [ADX_W-1:0] corruptAdx = '0, corruptVal = '0;
  logic [31:0]      firstSmp = '0, lastSmp = '0;
  logic             stallPrev = 1'b0;
  logic [31:0]      stallData = '0;

  // Sample s holds bytes 4s..4s+3, so sample 0 reads 0x03020100.
  function automatic logic [31:0] smpWord(int s);
    logic [7:0] b;
    b = 8'(s * 4);
    return {b + 8'd3, b + 8'd2, b + 8'd1, b};
  endfunction

  function automatic logic [127:0] lineWord(logic [ADX_W-1:0] adx);
    logic [127:0] l;
    int base;
    base = int'(adx >> 3) * 4;
    for (int k = 0; k < 4; k++) l[32*k +: 32] = smpWord(base + k);
    return l;
  endfunction

  task automatic checkOutput(string name, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick(int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Show-ahead return port: in-order, each line visible retLat cycles after its read.
  always begin : memModel
    logic             doPush, doPop;
    logic [ADX_W-1:0] pushAdx;
    @(negedge clk);
    doPush  = read_req && read_allowed;
    pushAdx = rd_adx;
    doPop   = get_return_data;
    @(posedge clk);
    #1;
    cyc++;
    if (!resetn) begin
      memQ.delete();
    end else begin
      if (doPop && memQ.size() > 0) begin
        if (return_adx !== memQ[0].adx) expErr = 1'b1;
        void'(memQ.pop_front());
      end
      if (doPush) memQ.push_back('{pushAdx, cyc + retLat});
    end
    if (memQ.size() > 0 && cyc >= memQ[0].rdy) begin
      has_return_data = 1'b1;
      return_data     = lineWord(memQ[0].adx);
      return_adx      = (corruptEn && memQ[0].adx == corruptAdx) ? corruptVal : memQ[0].adx;
    end else begin
      has_return_data = 1'b0;
      return_data     = '0;
      return_adx      = '0;
    end
  end

  always @(negedge clk) begin : monitor
    if (!resetn) begin
      stallPrev = 1'b0;
    end else begin
      checkOutput("read_req_qualified", 64'(read_req && !read_allowed), 0);
      if (read_req && read_allowed) begin
        readCnt++;
        if (expRd.size() == 0) checkOutput("unexpected_read", 64'(rd_adx), 64'hFFFF_FFFF);
        else                   checkOutput("rd_adx", 64'(rd_adx), 64'(expRd.pop_front()));
      end
      if (memQ.size() > maxOut) maxOut = memQ.size();
      if (busy) checkOutput("outstanding_le_max", 64'(memQ.size() <= MAXO), 1);
      if (stallPrev) begin
        checkOutput("stall_valid_held", 64'(sample_valid), 1);
        checkOutput("stall_data_held", 64'(sample_out), 64'(stallData));
      end
      if (sample_valid && sample_ready && !abort) begin
        if (expSmp.size() == 0) checkOutput("unexpected_sample", 64'(sample_out), 64'hFFFF_FFFF_FFFF);
        else                    checkOutput("sample_out", 64'(sample_out), 64'(expSmp.pop_front()));
        if (sentCnt == 0) firstSmp = sample_out;
        lastSmp = sample_out;
        sentCnt++;
      end
      checkOutput("adx_error", 64'(adx_error), 64'(expErr));
      if (done) begin
        doneCnt++;
        checkOutput("done_all_samples", 64'(expSmp.size()), 0);
        checkOutput("done_busy_low", 64'(busy), 0);
      end
      if (abort && busy) begin
        expSmp.delete();
        expRd.delete();
      end
      stallPrev = sample_valid && !sample_ready && !abort;
      stallData = sample_out;
    end
  end

  // Issue a start and derive the expected sample stream and line reads from the range.
  task automatic applyStimulus(int s, int n);
    start_sample = IDX_W'(s);
    sample_count = IDX_W'(n);
    start        = 1'b1;
    sentCnt      = 0;
    for (int i = s; i < s + n; i++) begin
      expSmp.push_back(smpWord(i));
      if (i == s || i % 4 == 0) expRd.push_back(ADX_W'((i / 4) * 8));
    end
    tick();
    start  = 1'b0;
    expErr = 1'b0;
  endtask

  task automatic waitDone(int budget, bit randReady);
    int d0;
    d0 = doneCnt;
    for (int i = 0; i < budget; i++) begin
      if (randReady) sample_ready = 1'($urandom_range(0, 1));
      tick();
      if (doneCnt != d0) break;
    end
    sample_ready = 1'b1;
    checkOutput("done_pulse_seen", 64'(doneCnt - d0), 1);
    checkOutput("done_one_cycle", 64'(done), 0);
    checkOutput("busy_after_done", 64'(busy), 0);
  endtask

  initial begin
    int r0, d0;
    tick(3);
    checkOutput("reset_busy", 64'(busy), 0);
    checkOutput("reset_done", 64'(done), 0);
    checkOutput("reset_read_req", 64'(read_req), 0);
    checkOutput("reset_valid", 64'(sample_valid), 0);
    checkOutput("reset_get", 64'(get_return_data), 0);
    resetn = 1'b1;
    tick(2);

    $display("[TB] aligned 8-sample transfer");
    r0 = readCnt;
    applyStimulus(0, 8);
    waitDone(200, 0);
    checkOutput("t1_reads", 64'(readCnt - r0), 2);
    checkOutput("t1_first", 64'(firstSmp), 64'h0302_0100);
    checkOutput("t1_last", 64'(lastSmp), 64'h1F1E_1D1C);

    $display("[TB] unaligned 5-sample transfer");
    r0 = readCnt;
    applyStimulus(6, 5);
    waitDone(200, 0);
    checkOutput("t2_reads", 64'(readCnt - r0), 2);
    checkOutput("t2_count", 64'(sentCnt), 5);
    checkOutput("t2_first", 64'(firstSmp), 64'h1B1A_1918);
    checkOutput("t2_last", 64'(lastSmp), 64'h2B2A_2928);

    $display("[TB] 40 samples, reads blocked, slow returns, random ready");
    r0 = readCnt; maxOut = 0; retLat = 6; read_allowed = 1'b0;
    applyStimulus(1, 40);
    for (int i = 0; i < 20; i++) begin
      sample_ready = 1'($urandom_range(0, 1));
      tick();
    end
    checkOutput("t3_no_read_blocked", 64'(readCnt - r0), 0);
    read_allowed = 1'b1;
    waitDone(2000, 1);
    checkOutput("t3_reads", 64'(readCnt - r0), 11);
    checkOutput("t3_count", 64'(sentCnt), 40);
    checkOutput("t3_max_outstanding", 64'(maxOut), 4);

    $display("[TB] abort mid-transfer then fresh start");
    retLat = 4; sample_ready = 1'b1;
    applyStimulus(0, 16);
    for (int i = 0; i < 200 && sentCnt < 3; i++) tick();
    checkOutput("t4_reached_3", 64'(sentCnt), 3);
    d0 = doneCnt;
    sample_ready = 1'b0; abort = 1'b1;
    tick();
    abort = 1'b0; sample_ready = 1'b1;
    for (int i = 0; i < 100 && busy; i++) tick();
    checkOutput("t4_busy_drop", 64'(busy), 0);
    checkOutput("t4_no_done", 64'(doneCnt - d0), 0);
    checkOutput("t4_drained", 64'(memQ.size()), 0);
    checkOutput("t4_sent", 64'(sentCnt), 3);
    applyStimulus(20, 4);
    waitDone(200, 0);
    checkOutput("t4_fresh_first", 64'(firstSmp), 64'h5352_5150);
    checkOutput("t4_fresh_last", 64'(lastSmp), 64'h5F5E_5D5C);

    $display("[TB] return address mismatch");
    retLat = 1; corruptEn = 1'b1; corruptAdx = ADX_W'(8); corruptVal = ADX_W'(16);
    applyStimulus(4, 8);
    waitDone(200, 0);
    corruptEn = 1'b0;
    checkOutput("t5_adx_error", 64'(adx_error), 1);
    checkOutput("t5_count", 64'(sentCnt), 8);
    checkOutput("t5_first", 64'(firstSmp), 64'h1312_1110);

    $display("[TB] zero-length transfer");
    r0 = readCnt;
    applyStimulus(0, 0);
    checkOutput("t6_adx_error_cleared", 64'(adx_error), 0);
    checkOutput("t6_busy_c1", 64'(busy), 1);
    checkOutput("t6_done_c1", 64'(done), 0);
    tick();
    checkOutput("t6_done_c2", 64'(done), 1);
    checkOutput("t6_busy_c2", 64'(busy), 0);
    tick();
    checkOutput("t6_done_c3", 64'(done), 0);
    checkOutput("t6_no_reads", 64'(readCnt - r0), 0);

    $display("[TB] asynchronous reset mid-transfer");
    retLat = 2;
    applyStimulus(0, 40);
    for (int i = 0; i < 100 && !sample_valid; i++) tick();
    checkOutput("t7_running", 64'(sample_valid), 1);
    @(negedge clk);
    #2;
    resetn = 1'b0;
    #1;
    checkOutput("t7_busy", 64'(busy), 0);
    checkOutput("t7_done", 64'(done), 0);
    checkOutput("t7_read_req", 64'(read_req), 0);
    checkOutput("t7_rd_adx", 64'(rd_adx), 0);
    checkOutput("t7_get", 64'(get_return_data), 0);
    checkOutput("t7_valid", 64'(sample_valid), 0);
    checkOutput("t7_sample_out", 64'(sample_out), 0);
    checkOutput("t7_adx_error", 64'(adx_error), 0);
    expSmp.delete();
    expRd.delete();
    expErr = 1'b0;
    tick(2);
    resetn = 1'b1;
    tick(2);
    r0 = readCnt;
    applyStimulus(3, 2);
    waitDone(200, 0);
    checkOutput("t7_reads", 64'(readCnt - r0), 2);
    checkOutput("t7_first", 64'(firstSmp), 64'h0F0E_0D0C);
    checkOutput("t7_last", 64'(lastSmp), 64'h1312_1110);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation did not finish, errors=%0d", errors);
    $fatal(1, "[TB] watchdog expired");
  end

endmodule

// File: doc/dram_unpacker.md
Name: dram_unpacker

Overview:
- Readback stage for the logic-capture path. Sits between the DDR memory interface's read port and the LogicCaptureTop upload logic.
- On a start command it issues 128-bit line reads for a sample range, keeping a bounded number in flight.
- It pops the returned lines, splits each into four 32-bit sample packets in order, and streams them out over a valid/ready handshake.

Parameters:
- IDX_W, 25: sample index width (2^25 samples × 4 B = 128 MB DDR2).
- ADX_W, 27: memory interface address width.
- MAX_OUTSTANDING, 4: maximum line reads issued but not yet popped; must not exceed the memory interface return buffer depth.

Ports:
- clk  in  1  system clock (soc_clk domain)
- resetn  in  1  asynchronous active-low reset
- start  in  1  one-cycle command pulse; ignored while busy
- start_sample  in  IDX_W  first sample index, sampled on start
- sample_count  in  IDX_W  number of samples, sampled on start
- abort  in  1  one-cycle pulse; cancels the transfer
- busy  out  1  transfer or drain in progress
- done  out  1  one-cycle pulse at transfer completion
- adx_error  out  1  sticky; return address mismatch
- read_req  out  1  one-cycle read command
- rd_adx  out  ADX_W  read line address, valid with read_req
- read_allowed  in  1  memory interface accepts read_req this cycle
- has_return_data  in  1  show-ahead return data present
- get_return_data  out  1  pop strobe; return_data is captured in the same cycle
- return_data  in  128  returned line
- return_adx  in  ADX_W  address of the returned line
- sample_out  out  32  sample packet
- sample_valid  out  1  sample_out valid
- sample_ready  in  1  consumer accepts the sample

Behaviour:
- Reset: all outputs 0, all counters 0, FSM in IDLE. Reset mid-transfer discards everything; the memory interface is reset alongside.
- Address map:
  - Line index = sample[IDX_W-1:2].
  - rd_adx = zero-extended {line, 3'b000}, i.e. a stride of 8 per line.
  - Sample lane k = sample[1:0] occupies return_data[32k+31:32k]; lane 0 is at the LSB.
- Start command: on start in IDLE, latch the following and enter RUN; busy goes high the next cycle.
  - lane0 = start_sample[1:0]
  - first line = start_sample >> 2
  - lines_total = (lane0 + sample_count + 3) >> 2, computed at IDX_W+1 bits
  - sample_count == 0 enters DONE directly: done pulses on the 2nd cycle after start, no reads issued.
- Issue rule: read_req=1 for one cycle when all three hold: RUN, lines_issued < lines_total, outstanding < MAX_OUTSTANDING. It is qualified by read_allowed in the same cycle; if read_allowed is low, no request is made. rd_adx advances by 8 per issue, and addresses wrap modulo 2^ADX_W.
- Outstanding counter: +1 on issue, -1 on get_return_data; a simultaneous issue and get leaves it unchanged. It never exceeds MAX_OUTSTANDING.
- Fetch rule:
  - get_return_data=1 when the holding register is empty and has_return_data=1. return_data is latched the same cycle.
  - Lane pointer loads lane0 for the first line, 0 for later lines.
  - sample_valid rises the next cycle, so there is a 1-cycle bubble per line.
- Address check: if return_adx ≠ expected fetch address (first-line adx + 8×lines_fetched), set adx_error. The data is still emitted. adx_error clears on the next accepted start.
- Output: sample_out/sample_valid are held stable while valid && !ready. On each handshake, advance the lane and increment samples_sent. The holding register empties after lane 3 is consumed or when samples_sent reaches sample_count; the trailing lanes of the last line are dropped.
- Completion: when samples_sent == sample_count and outstanding == 0, done pulses one cycle and the FSM enters IDLE; busy goes low in the same cycle as done.
- Abort (RUN): stop issuing, clear sample_valid, go to DRAIN. DRAIN pops and discards returns until outstanding == 0, then goes to IDLE with no done pulse. Abort in IDLE or DRAIN is ignored.
- start and abort in the same cycle: abort wins, i.e. start is ignored.
- FSM: IDLE → RUN (start) → DONE (complete) → IDLE; RUN → DRAIN (abort) → IDLE.

Decomposition:
- Package lc_mem_pkg holds:
  - constants SAMPLE_W=32, LINE_W=128, SAMPLES_PER_LINE=4, LINE_ADX_STRIDE=8
  - FSM state enum
  - function sample_to_line_adx
- One sub-module, dram_read_issuer: owns the issue counter, the outstanding counter and the read_req/rd_adx generation. The top level owns fetch, unpacking, handshake and FSM.

Test Plan:
1. start_sample=0, sample_count=8, memory model returns lines 0x..03020100-style patterns, ready=1 → exactly 2 reads (adx 0, 8), samples emitted in order lane0..3, done once, busy low afterwards.
2. start_sample=6, sample_count=5 → reads adx 8 and 16; samples = line1 lanes 2,3 then line2 lanes 0,1,2; lane 3 dropped.
3. sample_count=40, read_allowed held 0 for 20 cycles then 1, has_return_data delayed → outstanding never exceeds 4; all 40 samples emitted; ready toggled randomly, sample_out stable while stalled.
4. Abort after 3 of 16 samples with 2 lines outstanding → no more samples, both lines popped and discarded, no done, busy drops; an immediate new start of 4 samples returns correct fresh data.
5. Memory model returns return_adx=0x10 when 0x08 is expected → adx_error=1 and data still emitted; the next start clears adx_error.
6. sample_count=0 → done two cycles after start, no read_req. Assert resetn low mid-RUN → all outputs 0 asynchronously.
